// File: rtl/storage_fifo_pkg.sv
// Shared definitions for the storage block family: sizing helper and the
// reset values that every storage block clears to.
package storage_fifo_pkg;

  // Ceiling log2 for sizing pointers and addresses at elaboration time.
  function automatic int clog2(input int value);
    int result;
    result = 0;
    while ((1 << result) < value) begin
      result = result + 1;
    end
    return result;
  endfunction

  localparam int MAX_WORD_W = 64;

  localparam logic [MAX_WORD_W-1:0] ZERO_WORD = '0;

  typedef struct packed {
    logic overflow;
    logic underflow;
  } err_flags_t;

  localparam err_flags_t ZERO_FLAGS = '{overflow: 1'b0, underflow: 1'b0};

endpackage

// File: rtl/storage_regfile.sv
// DEPTH x WIDTH flip-flop array: one synchronous write port, one
// combinational read port. Contents are deliberately not reset.
module storage_regfile
  import storage_fifo_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4,
  localparam int ADDR_W = clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [WIDTH-1:0]  wr_data,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic [WIDTH-1:0]  rd_data
);

  logic [WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wr_addr] <= wr_data;
    end
  end

  // Read returns the pre-edge contents, so a same-cycle write to the slot
  // being read never bypasses into the read.
  assign rd_data = mem[rd_addr];

endmodule

// File: rtl/storage_fifo.sv
// Flip-flop FIFO with wrap-bit pointers, registered one-cycle read data,
// and sticky overflow/underflow flags.
module storage_fifo
  import storage_fifo_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4,
  localparam int ADDR_W = clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              wr_en,
  input  logic [WIDTH-1:0]  wr_data,
  output logic              full,
  input  logic              rd_en,
  output logic [WIDTH-1:0]  rd_data,
  output logic              rd_valid,
  output logic              empty,
  output logic [ADDR_W:0]   count,
  output logic              overflow,
  output logic              underflow
);

  // Handshake: a push is accepted when wr_en is high and the FIFO is not
  // full, or a pop is accepted in the same cycle (full + read frees a slot).
  // A pop is accepted when rd_en is high and the FIFO is not empty; its word
  // appears on rd_data with rd_valid=1 in the following cycle. Rejected
  // requests leave pointers and storage untouched and raise a sticky flag.

  localparam logic [ADDR_W:0] PTR_ONE = {{ADDR_W{1'b0}}, 1'b1};

  logic [ADDR_W:0]  wr_ptr;
  logic [ADDR_W:0]  rd_ptr;
  logic             push_ok;
  logic             pop_ok;
  logic [WIDTH-1:0] mem_rd_data;
  err_flags_t       flags;

  // Status derives only from registered pointers.
  assign empty = (wr_ptr == rd_ptr);
  assign full  = (wr_ptr[ADDR_W] != rd_ptr[ADDR_W]) &&
                 (wr_ptr[ADDR_W-1:0] == rd_ptr[ADDR_W-1:0]);
  assign count = wr_ptr - rd_ptr;

  assign push_ok = wr_en & (~full | rd_en);
  assign pop_ok  = rd_en & ~empty;

  assign overflow  = flags.overflow;
  assign underflow = flags.underflow;

  storage_regfile #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH)
  ) u_regfile (
    .clk     (clk),
    .wr_en   (push_ok),
    .wr_addr (wr_ptr[ADDR_W-1:0]),
    .wr_data (wr_data),
    .rd_addr (rd_ptr[ADDR_W-1:0]),
    .rd_data (mem_rd_data)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr <= '0;
    end else if (push_ok) begin
      wr_ptr <= wr_ptr + PTR_ONE;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rd_ptr <= '0;
    end else if (pop_ok) begin
      rd_ptr <= rd_ptr + PTR_ONE;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rd_data  <= ZERO_WORD[WIDTH-1:0];
      rd_valid <= 1'b0;
    end else begin
      rd_valid <= pop_ok;
      if (pop_ok) begin
        rd_data <= mem_rd_data;
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      flags <= ZERO_FLAGS;
    end else begin
      if (wr_en & full & ~rd_en) begin
        flags.overflow <= 1'b1;
      end
      if (rd_en & empty) begin
        flags.underflow <= 1'b1;
      end
    end
  end

endmodule

// File: doc/storage_fifo.md
Name: storage_fifo

Overview:
- Synchronous first-in first-out buffer built from flip-flop storage in the storage block family.
- Provides the read side matching a write side: the producer pushes words, the consumer pops them in order, and full/empty flags provide the handshake.
- Sits between a producer and a consumer on the same clock; used as a small elastic buffer of 2..16 entries.

Parameters:
- WIDTH, 8, data word width in bits.
- DEPTH, 4, number of entries. Must be a power of two, 2..16.
- ADDR_W, clog2(DEPTH), derived local constant, not overridable; pointer index width.

Ports:
- clk  input  1  single clock, all state updates on its rising edge.
- reset  input  1  asynchronous, active-low; 0 clears all state immediately.
- wr_en  input  1  push request, sampled on rising clk.
- wr_data  input  WIDTH  word to push; valid when wr_en=1.
- full  output  1  1 when count==DEPTH.
- rd_en  input  1  pop request, sampled on rising clk.
- rd_data  output  WIDTH  registered output holding the last popped word.
- rd_valid  output  1  1 for exactly the cycle after an accepted pop; qualifies rd_data.
- empty  output  1  1 when count==0.
- count  output  ADDR_W+1  number of stored words, 0..DEPTH.
- overflow  output  1  sticky flag: push attempted while full with no pop accepted in the same cycle.
- underflow  output  1  sticky flag: pop attempted while empty.

Behaviour:
- Reset (reset=0, asynchronous):
  - Write and read pointers are 0; count is 0; empty=1; full=0.
  - rd_data=0; rd_valid=0; overflow=0; underflow=0.
  - Memory contents are not reset.
- Pointers:
  - wr_ptr and rd_ptr are ADDR_W+1 bits wide; the MSB is a wrap bit.
  - The index is the low ADDR_W bits, and each pointer increments modulo 2*DEPTH.
  - empty = (wr_ptr==rd_ptr).
  - full = same index with wrap bits differing.
  - count = wr_ptr - rd_ptr, truncated to ADDR_W+1 bits.
  - full, empty and count are registered or derived only from registered pointers; no combinational path from wr_en/rd_en.
- Accept rules, evaluated each rising edge:
  - push_ok = wr_en & (~full | rd_en).
  - pop_ok = rd_en & ~empty.
- On push_ok: mem[wr_ptr index] <= wr_data; wr_ptr increments.
- On pop_ok: rd_data <= mem[rd_ptr index]; rd_ptr increments; rd_valid <= 1.
  - Otherwise rd_valid <= 0 and rd_data holds its value.
- Read latency is one cycle: the word appears on rd_data in the cycle after the rd_en edge.
- Simultaneous events:
  - Full with wr_en=1 and rd_en=1: both are accepted; count stays DEPTH; the oldest word is popped and the new word is written into the freed slot.
  - Empty with wr_en=1 and rd_en=1: only the push is accepted (no fall-through); underflow is set; count becomes 1.
  - Non-full and non-empty with both asserted: both are accepted; count is unchanged.
- Error flags:
  - overflow is set when wr_en & full & ~rd_en.
  - underflow is set when rd_en & empty.
  - Both are sticky until reset; rejected operations do not change pointers or memory.
- Wrap-around: pointers wrap transparently. Ordering is preserved across any number of wraps.
- Reset mid-operation: everything returns to reset values asynchronously, and any in-flight rd_valid drops at once. The first push after reset release lands in index 0.

Decomposition:
- Shared storage package:
  - clog2 constant function.
  - Reset-value constants (zero word, zero flags) reused by other storage blocks.
- Natural sub-module: storage_regfile. It holds the DEPTH x WIDTH flip-flop array with one synchronous write port and one combinational read port. The FIFO instantiates it and keeps the pointers, flags and rd_data register itself.

Test Plan:
- Reset then idle (DEPTH=4, WIDTH=8) -> empty=1, full=0, count=0, rd_data=0x00, rd_valid=0, overflow=0, underflow=0.
- Push 0x11,0x22,0x33,0x44 then pop 4 times -> count 1,2,3,4 with full=1 at 4; pops give rd_data 0x11,0x22,0x33,0x44, each with rd_valid high one cycle after rd_en; empty=1 at end.
- When full, push 0x55 alone -> overflow=1, count stays 4; the following pops return 0x11..0x44 with 0x55 absent.
- When full, push 0x66 with rd_en the same cycle -> rd_data=0x11, count stays 4; subsequent pops return 0x22,0x33,0x44,0x66.
- When empty, rd_en=1 and wr_en=1 with 0x77 -> underflow=1, rd_valid=0, count=1; the next pop returns 0x77.
- Drive 10 push/pop pairs to wrap the pointers twice, then assert reset low mid-cycle with 2 words stored -> data order is preserved before the reset; after reset, count=0, empty=1 and rd_valid=0 immediately, without waiting for a clock edge.
